// File: rtl/eel_fetch_pkg.sv
// eel_fetch_pkg
// Shared types and constants for the EEL instruction fetch stage.
//   fetch_entry_t : one queued fetch result {pc, instr, misalign}
//   FETCH_MODE_E  : fetch sequencer mode (RUN / FAULT / HALT)
//   NOP_INSTR     : filler instruction carried by a misaligned-target fault entry
//   PC_STEP       : byte increment between sequential fetches
package eel_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        HALT  = 2'd2
    } FETCH_MODE_E;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/eel_fetch_skid_buf.sv
// eel_fetch_skid_buf
// Two-entry FIFO of fetch_entry_t sitting between IMEM capture and decode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : drop the head this cycle
//   flush      : discard all contents (redirect)
//   count      : number of valid entries (0..2)
//   head       : oldest entry; contents are stale when count == 0
module eel_fetch_skid_buf
    import eel_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt order.
    assign do_pop  = pop  & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/eel_fetch_unit.sv
// eel_fetch_unit
// Instruction fetch stage of the EEL core. Owns the PC, reads IMEM
// combinationally and captures {pc, instr} into a 2-entry skid queue that
// feeds decode over a valid/ready handshake. REDIRECT reloads the PC and
// flushes queued work in a single cycle.
// Build option:
//   EEL_FETCH_ALIGN_CHECK_EN : misaligned redirect targets produce one
//   fault entry (NOP, misalign=1) and halt fetching until an aligned
//   redirect or reset. Undefined: targets are forced word aligned.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   REDIRECT(_PC)   : load a new PC and flush the queue
//   IMEM_RDEN/ADDR  : IMEM read enable and word address (PC[ADDR_DEPTH+1:2])
//   IMEM_DATA       : IMEM output, valid in the same cycle as IMEM_ADDR
//   IF_VALID/READY  : decode handshake for the queue head
//   IF_INSTR/PC     : head entry, 0 when the queue is empty
//   IF_MISALIGN     : head carries a misaligned-target fault
module eel_fetch_unit
    import eel_fetch_pkg::*;
#(
    parameter int          ADDR_DEPTH = 14,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REDIRECT,
    input  logic [31:0]           REDIRECT_PC,
    output logic                  IMEM_RDEN,
    output logic [ADDR_DEPTH-1:0] IMEM_ADDR,
    input  logic [31:0]           IMEM_DATA,
    output logic                  IF_VALID,
    input  logic                  IF_READY,
    output logic [31:0]           IF_INSTR,
    output logic [31:0]           IF_PC,
    output logic                  IF_MISALIGN
);

    logic [31:0]  pc;
    FETCH_MODE_E  mode;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t push_data;
    logic         q_valid;
    logic         q_room;
    logic         pop;
    logic         push;
    logic         fetch;
    logic         fault_push;
    logic [31:0]  target;
    FETCH_MODE_E  redirect_mode;
    logic         quiet;

    // Reset and redirect both suppress any handshake or IMEM access this cycle.
    assign quiet    = RST | REDIRECT;
    assign q_valid  = (q_count != 2'd0);
    assign IF_VALID = q_valid & ~quiet;
    assign pop      = IF_VALID & IF_READY;
    // A full queue may still accept a push when the head leaves the same cycle.
    assign q_room   = (q_count != 2'd2) | pop;
    assign fetch    = (mode == RUN) & ~quiet & q_room;
    assign push     = fetch | fault_push;

    assign IMEM_RDEN = fetch;
    assign IMEM_ADDR = pc[ADDR_DEPTH+1:2];

`ifdef EEL_FETCH_ALIGN_CHECK_EN
    assign target        = REDIRECT_PC;
    assign redirect_mode = (REDIRECT_PC[1:0] != 2'b00) ? FAULT : RUN;
    // The fault entry is synthesized locally; IMEM stays idle for it.
    assign fault_push    = (mode == FAULT) & ~quiet & q_room;
    assign IF_MISALIGN   = (q_valid & ~RST) ? q_head.misalign : 1'b0;
`else
    logic unused_bits;
    assign target        = {REDIRECT_PC[31:2], 2'b00};
    assign redirect_mode = RUN;
    assign fault_push    = 1'b0;
    assign IF_MISALIGN   = 1'b0;
    assign unused_bits   = ^{REDIRECT_PC[1:0], q_head.misalign};
`endif

    always_comb begin
        push_data          = '0;
        push_data.pc       = pc;
        push_data.instr    = IMEM_DATA;
        push_data.misalign = 1'b0;
        if (fault_push) begin
            push_data.instr    = NOP_INSTR;
            push_data.misalign = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc   <= RESET_PC;
            mode <= RUN;
        end else if (REDIRECT) begin
            pc   <= target;
            mode <= redirect_mode;
        end else begin
            if (fetch)      pc   <= pc + PC_STEP;
            if (fault_push) mode <= HALT;
        end
    end

    eel_fetch_skid_buf u_skid (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (REDIRECT),
        .count     (q_count),
        .head      (q_head)
    );

    assign IF_INSTR = (q_valid & ~RST) ? q_head.instr : 32'h0;
    assign IF_PC    = (q_valid & ~RST) ? q_head.pc    : 32'h0;

endmodule

// File: tb/tb_eel_fetch_unit.sv
module tb_eel_fetch_unit;
    import eel_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        IF_READY = 1'b0;

    logic        IMEM_RDEN, IF_VALID, IF_MISALIGN;
    logic [13:0] IMEM_ADDR;
    logic [31:0] IMEM_DATA, IF_INSTR, IF_PC;

    logic        w_rden, w_valid, w_misalign;
    logic [13:0] w_addr;
    logic [31:0] w_data, w_instr, w_pc;

    int n_checks = 0;
    int n_fail   = 0;
    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    // IMEM image: every word distinct and derived from its address.
    function automatic logic [31:0] img(input logic [13:0] a);
        return {2'b10, a, 2'b01, ~a};
    endfunction

    function automatic fetch_entry_t ent(input logic [31:0] p, input logic [31:0] ins, input logic mis);
        fetch_entry_t e;
        e.pc = p; e.instr = ins; e.misalign = mis;
        return e;
    endfunction

    function automatic fetch_entry_t seq(input logic [31:0] p);
        logic [31:0] q;
        q = p;
        return ent(q, img(q[15:2]), 1'b0);
    endfunction

    assign IMEM_DATA = img(IMEM_ADDR);
    assign w_data    = img(w_addr);

    eel_fetch_unit #(.ADDR_DEPTH(14), .RESET_PC(32'h0)) dut (
        .CLK(clk), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IMEM_RDEN(IMEM_RDEN), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
        .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_INSTR(IF_INSTR),
        .IF_PC(IF_PC), .IF_MISALIGN(IF_MISALIGN)
    );

    eel_fetch_unit #(.ADDR_DEPTH(14), .RESET_PC(32'h0000_FFFC)) u_wrap (
        .CLK(clk), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IMEM_RDEN(w_rden), .IMEM_ADDR(w_addr), .IMEM_DATA(w_data),
        .IF_VALID(w_valid), .IF_READY(IF_READY), .IF_INSTR(w_instr),
        .IF_PC(w_pc), .IF_MISALIGN(w_misalign)
    );

    // Pops the scoreboard on each accepted head, starting in the current cycle.
    task automatic sb_drain(input string name, input int budget, input bit gapless);
        int cyc = 0;
        fetch_entry_t e;
        IF_READY = 1'b1;
        #0;
        while (sb.size() > 0 && cyc < budget) begin
            if (IF_VALID) begin
                e = sb.pop_front();
                n_checks++;
                if ({IF_PC, IF_INSTR, IF_MISALIGN} !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h instr=%h mis=%b expected pc=%h instr=%h mis=%b",
                             name, IF_PC, IF_INSTR, IF_MISALIGN, e.pc, e.instr, e.misalign);
                end
            end else if (gapless) begin
                n_checks++; n_fail++;
                $display("FAIL %s_gap: got IF_VALID=0 expected 1", name);
            end
            cyc++;
            if (sb.size() > 0) begin @(negedge clk); #1; end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending entries expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset(input bit rdy);
        @(negedge clk);
        RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; IF_READY = rdy;
        @(negedge clk); @(negedge clk);
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; IF_READY = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (IMEM_RDEN !== 1'b0) begin n_fail++; $display("FAIL rst_rden: got %b expected 0", IMEM_RDEN); end
        n_checks++; if (IF_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", IF_VALID); end
        n_checks++; if (IF_INSTR !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", IF_INSTR); end
        n_checks++; if (IF_PC !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", IF_PC); end
        n_checks++; if (IF_MISALIGN !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b expected 0", IF_MISALIGN); end
        n_checks++; if ({w_rden, w_valid, w_pc} !== 34'h0) begin n_fail++; $display("FAIL rst_wrap: got rden=%b valid=%b pc=%h expected 0", w_rden, w_valid, w_pc); end
    endtask

    task automatic test_stream;
        @(negedge clk); RST = 1'b0; #1;
        n_checks++; if ({IMEM_RDEN, IF_VALID} !== 2'b10) begin n_fail++; $display("FAIL first_fetch: got rden=%b valid=%b expected rden=1 valid=0", IMEM_RDEN, IF_VALID); end
        n_checks++; if (IMEM_ADDR !== 14'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 0", IMEM_ADDR); end
        @(negedge clk); #1;
        n_checks++; if (IF_VALID !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", IF_VALID); end
        sb.push_back(seq(32'h0)); sb.push_back(seq(32'h4)); sb.push_back(seq(32'h8));
        sb_drain("stream", 3, 1'b1);
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        @(negedge clk); #1;
        n_checks++; if ({IF_VALID, IF_PC} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL stall_first: got valid=%b pc=%h expected 1/0", IF_VALID, IF_PC); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({IMEM_RDEN, IMEM_ADDR, IF_VALID, IF_PC} !== {1'b0, 14'h2, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL stall_hold: got rden=%b addr=%h valid=%b pc=%h expected 0/2/1/0", IMEM_RDEN, IMEM_ADDR, IF_VALID, IF_PC);
            end
        end
        @(negedge clk); IF_READY = 1'b1; #1;
        n_checks++; if (IMEM_RDEN !== 1'b1) begin n_fail++; $display("FAIL stall_release_rden: got %b expected 1", IMEM_RDEN); end
        sb.push_back(seq(32'h0)); sb.push_back(seq(32'h4)); sb.push_back(seq(32'h8));
        sb_drain("stall_release", 3, 1'b1);
    endtask

    task automatic test_redirect_full;
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk); REDIRECT = 1'b1; REDIRECT_PC = 32'h100; #1;
        n_checks++; if ({IF_VALID, IMEM_RDEN} !== 2'b00) begin n_fail++; $display("FAIL redir_cycle: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        @(negedge clk); REDIRECT = 1'b0; IF_READY = 1'b1; #1;
        n_checks++; if ({IF_VALID, IMEM_RDEN, IMEM_ADDR} !== {2'b01, 14'h40}) begin n_fail++; $display("FAIL redir_next: got valid=%b rden=%b addr=%h expected 0/1/40", IF_VALID, IMEM_RDEN, IMEM_ADDR); end
        @(negedge clk); #1;
        sb.push_back(seq(32'h100)); sb.push_back(seq(32'h104));
        sb_drain("redir", 2, 1'b1);
    endtask

    task automatic test_wrap;
        do_reset(1'b1);
        n_checks++; if ({w_rden, w_addr} !== {1'b1, 14'h3FFF}) begin n_fail++; $display("FAIL wrap_addr0: got rden=%b addr=%h expected 1/3fff", w_rden, w_addr); end
        @(negedge clk); #1;
        n_checks++; if ({w_valid, w_pc, w_instr} !== {1'b1, 32'h0000_FFFC, img(14'h3FFF)}) begin n_fail++; $display("FAIL wrap_head0: got valid=%b pc=%h instr=%h expected 1/0000fffc/%h", w_valid, w_pc, w_instr, img(14'h3FFF)); end
        n_checks++; if (w_addr !== 14'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0", w_addr); end
        @(negedge clk); #1;
        n_checks++; if ({w_valid, w_pc, w_instr, w_misalign} !== {1'b1, 32'h0001_0000, img(14'h0), 1'b0}) begin n_fail++; $display("FAIL wrap_head1: got valid=%b pc=%h instr=%h expected 1/00010000/%h", w_valid, w_pc, w_instr, img(14'h0)); end
    endtask

    task automatic test_misalign;
        do_reset(1'b1);
        REDIRECT = 1'b1; REDIRECT_PC = 32'h102; #1;
        n_checks++; if ({IF_VALID, IMEM_RDEN} !== 2'b00) begin n_fail++; $display("FAIL mis_redir: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        @(negedge clk); REDIRECT = 1'b0; #1;
`ifdef EEL_FETCH_ALIGN_CHECK_EN
        n_checks++; if ({IF_VALID, IMEM_RDEN} !== 2'b00) begin n_fail++; $display("FAIL mis_fault: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        @(negedge clk); #1;
        sb.push_back(ent(32'h102, NOP_INSTR, 1'b1));
        sb_drain("mis_entry", 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({IF_VALID, IMEM_RDEN} !== 2'b00) begin n_fail++; $display("FAIL mis_halt: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        end
        @(negedge clk); REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
        @(negedge clk); REDIRECT = 1'b0; #1;
        n_checks++; if ({IMEM_RDEN, IMEM_ADDR} !== {1'b1, 14'h80}) begin n_fail++; $display("FAIL mis_resume: got rden=%b addr=%h expected 1/80", IMEM_RDEN, IMEM_ADDR); end
        @(negedge clk); #1;
        sb.push_back(seq(32'h200)); sb.push_back(seq(32'h204));
        sb_drain("mis_resume_seq", 2, 1'b1);
`else
        n_checks++; if ({IMEM_RDEN, IMEM_ADDR} !== {1'b1, 14'h40}) begin n_fail++; $display("FAIL mis_aligned: got rden=%b addr=%h expected 1/40", IMEM_RDEN, IMEM_ADDR); end
        @(negedge clk); #1;
        sb.push_back(seq(32'h100)); sb.push_back(seq(32'h104));
        sb_drain("mis_forced", 2, 1'b1);
`endif
    endtask

    task automatic test_rst_full;
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk); RST = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h300; #1;
        n_checks++; if ({IF_VALID, IMEM_RDEN, IF_PC} !== 34'h0) begin n_fail++; $display("FAIL rstfull_cycle: got valid=%b rden=%b pc=%h expected 0", IF_VALID, IMEM_RDEN, IF_PC); end
        @(negedge clk); RST = 1'b0; REDIRECT = 1'b0; IF_READY = 1'b1; #1;
        n_checks++; if ({IF_VALID, IMEM_RDEN, IMEM_ADDR} !== {2'b01, 14'h0}) begin n_fail++; $display("FAIL rstfull_next: got valid=%b rden=%b addr=%h expected 0/1/0", IF_VALID, IMEM_RDEN, IMEM_ADDR); end
        @(negedge clk); #1;
        sb.push_back(seq(32'h0)); sb.push_back(seq(32'h4));
        sb_drain("rstfull", 2, 1'b1);
    endtask

    // Random decode back-pressure against an occupancy/PC model.
    task automatic test_back_to_back;
        int          occ = 0;
        logic [31:0] fpc = 32'h0;
        bit          hs, exp_rden;
        fetch_entry_t e;
        do_reset(1'b1);
        for (int i = 0; i < 60; i++) begin
            IF_READY = 1'($urandom_range(0, 1));
            #1;
            hs = (occ > 0) && IF_READY;
            exp_rden = (occ < 2) || hs;
            n_checks++; if (IF_VALID !== (occ > 0)) begin n_fail++; $display("FAIL b2b_valid: got %b expected %b", IF_VALID, occ > 0); end
            n_checks++; if (IMEM_RDEN !== exp_rden) begin n_fail++; $display("FAIL b2b_rden: got %b expected %b", IMEM_RDEN, exp_rden); end
            if (exp_rden) begin
                n_checks++; if (IMEM_ADDR !== fpc[15:2]) begin n_fail++; $display("FAIL b2b_addr: got %h expected %h", IMEM_ADDR, fpc[15:2]); end
                sb.push_back(seq(fpc));
                fpc = fpc + 32'd4;
            end
            if (hs) begin
                e = sb.pop_front();
                n_checks++;
                if ({IF_PC, IF_INSTR, IF_MISALIGN} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_data: got pc=%h instr=%h expected pc=%h instr=%h", IF_PC, IF_INSTR, e.pc, e.instr);
                end
            end
            occ = occ + (exp_rden ? 1 : 0) - (hs ? 1 : 0);
            @(negedge clk);
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_misalign();
        test_rst_full();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
